// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory arbiter: FSM states and requester ids.
// Used by imem_arbiter and rr_arb2.
package imem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam logic REQ_FETCH  = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that did not win last time. Grant is one-hot (bit 0 fetch, bit 1 loader).
module rr_arb2
    import imem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_req[REQ_FETCH] && i_req[REQ_LOADER]) begin
            if (i_last_gnt == REQ_LOADER) begin
                o_gnt[REQ_FETCH] = 1'b1;
            end else begin
                o_gnt[REQ_LOADER] = 1'b1;
            end
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates a fetch port and a loader port onto one single-cycle-read memory.
// Define IMEM_ARB_LOCK_EN to add l_lock, which holds the memory for loader bursts.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // fetch side
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    // loader side
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
`ifdef IMEM_ARB_LOCK_EN
    input  logic              l_lock,
`endif
    // memory side
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    // debug
    output arb_state_e        o_dbg_state
);

    // Handshake: a request is accepted in the cycle where req=1 and gnt=1; the
    // requester holds req/addr/data stable until then. The accepted access's
    // response appears as a one-cycle rvalid pulse on the following cycle.

    arb_state_e        r_state;
    logic              r_last_gnt;
    logic              r_f_rvalid;
    logic              r_l_rvalid;
    logic [DATA_W-1:0] r_f_rdata;
    logic [DATA_W-1:0] r_l_rdata;

    logic [1:0]        w_rr_gnt;
    logic              w_lock_hold;
    logic              w_f_acc;
    logic              w_l_acc;
    logic              w_any_acc;

`ifdef IMEM_ARB_LOCK_EN
    assign w_lock_hold = (r_state == LOCKED) && l_lock;
`else
    assign w_lock_hold = 1'b0;
`endif

    rr_arb2 u_rr_arb2 (
        .i_req      ({l_req, f_req}),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_rr_gnt)
    );

    always_comb begin
        w_f_acc = 1'b0;
        w_l_acc = 1'b0;
        if (rst) begin
            if (w_lock_hold) begin
                w_l_acc = l_req;
            end else begin
                w_f_acc = w_rr_gnt[REQ_FETCH];
                w_l_acc = w_rr_gnt[REQ_LOADER];
            end
        end
    end

    assign w_any_acc = w_f_acc | w_l_acc;
    assign f_gnt     = w_f_acc;
    assign l_gnt     = w_l_acc;
    assign m_en      = w_any_acc;
    assign m_we      = w_l_acc & l_we;
    assign m_addr    = w_f_acc ? f_addr : (w_l_acc ? l_addr : '0);
    assign m_wdata   = w_any_acc ? l_wdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_last_gnt <= REQ_LOADER;
            r_f_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
            r_f_rdata  <= '0;
            r_l_rdata  <= '0;
        end else begin
            r_f_rvalid <= w_f_acc;
            r_l_rvalid <= w_l_acc;
            if (w_f_acc) begin
                r_f_rdata <= m_rdata;
            end
            // A write is acknowledged with zero data rather than the old contents.
            if (w_l_acc) begin
                r_l_rdata <= l_we ? '0 : m_rdata;
            end
            if (w_f_acc) begin
                r_last_gnt <= REQ_FETCH;
            end else if (w_l_acc) begin
                r_last_gnt <= REQ_LOADER;
            end
`ifdef IMEM_ARB_LOCK_EN
            case (r_state)
                IDLE:    if (w_l_acc && l_lock) r_state <= LOCKED;
                LOCKED:  if (!l_lock) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
`else
            r_state <= IDLE;
`endif
        end
    end

    // Masking with rst drops a response that was due in the first reset cycle.
    assign f_rvalid    = r_f_rvalid & rst;
    assign l_rvalid    = r_l_rvalid & rst;
    assign f_rdata     = rst ? r_f_rdata : '0;
    assign l_rdata     = rst ? r_l_rdata : '0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model. Lock scenarios need IMEM_ARB_LOCK_EN.
module tb_imem_arbiter;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        l_req = 1'b0;
    logic        l_we = 1'b0;
    logic [31:0] l_addr = '0;
    logic [31:0] l_wdata = '0;
    logic        l_gnt, l_rvalid;
    logic [31:0] l_rdata;
    logic        l_lock = 1'b0;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    arb_state_e  dbg_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_gnt       (f_gnt),
        .f_rvalid    (f_rvalid),
        .f_rdata     (f_rdata),
        .l_req       (l_req),
        .l_we        (l_we),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .l_gnt       (l_gnt),
        .l_rvalid    (l_rvalid),
        .l_rdata     (l_rdata),
`ifdef IMEM_ARB_LOCK_EN
        .l_lock      (l_lock),
`endif
        .m_en        (m_en),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .o_dbg_state (dbg_state)
    );

    // Memory attached to the DUT: 64 words, word index = addr[7:2], so addresses wrap.
    logic [31:0] mem [64];
    assign m_rdata = mem[m_addr[7:2]];
    always @(posedge clk) begin
        if (m_en && m_we) mem[m_addr[7:2]] <= m_wdata;
    end

    // Reference model: who wins (0 none, 1 fetch, 2 loader) and the expected responses.
    logic [31:0] mdl_mem [64];
    int          mdl_last = 2;
    bit          mdl_locked = 1'b0;
    bit          ef_v = 1'b0;
    bit          el_v = 1'b0;
    logic [31:0] ef_d = '0;
    logic [31:0] el_d = '0;
    int          win = 0;

    function automatic int model_winner();
        if (!rst) return 0;
        if (mdl_locked && l_lock) return l_req ? 2 : 0;
        if (f_req && l_req) return (mdl_last == 2) ? 1 : 2;
        if (f_req) return 1;
        if (l_req) return 2;
        return 0;
    endfunction

    task automatic model_step();
        if (!rst) begin
            ef_v = 1'b0; el_v = 1'b0; ef_d = '0; el_d = '0;
            mdl_last = 2; mdl_locked = 1'b0;
            return;
        end
        ef_v = (win == 1);
        el_v = (win == 2);
        if (win == 1) begin
            ef_d = mdl_mem[f_addr[7:2]];
            mdl_last = 1;
        end else if (win == 2) begin
            if (l_we) begin
                mdl_mem[l_addr[7:2]] = l_wdata;
                el_d = '0;
            end else begin
                el_d = mdl_mem[l_addr[7:2]];
            end
            mdl_last = 2;
        end
        if (mdl_locked) begin
            if (!l_lock) mdl_locked = 1'b0;
        end else if (win == 2 && l_lock) begin
            mdl_locked = 1'b1;
        end
    endtask

    task automatic drive(input bit fr, input logic [31:0] fa, input bit lr, input bit lwe,
                         input logic [31:0] la, input logic [31:0] lwd, input bit lk);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd; l_lock = lk;
    endtask

    task automatic settle();
        @(negedge clk);
        win = model_winner();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        settle(); tick();
        settle(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1, 32'h8, 1, 1, 32'h10, 32'h55, 1);
        settle(); tick();
        settle();
        checks++; if (f_gnt !== 1'b0) begin errors++; $display("FAIL rst_f_gnt: got %b want 0", f_gnt); end
        checks++; if (l_gnt !== 1'b0) begin errors++; $display("FAIL rst_l_gnt: got %b want 0", l_gnt); end
        checks++; if (m_en !== 1'b0 || m_we !== 1'b0) begin errors++; $display("FAIL rst_m_en_we: got %b%b want 00", m_en, m_we); end
        checks++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin errors++; $display("FAIL rst_m_bus: got %h/%h want 0/0", m_addr, m_wdata); end
        checks++; if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", f_rvalid, l_rvalid); end
        checks++; if (f_rdata !== 32'h0 || l_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", f_rdata, l_rdata); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_fetch_only();
        do_reset();
        drive(1, 32'h8, 0, 0, 0, 32'h1234, 0);
        settle();
        checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin errors++; $display("FAIL fo_gnt: got f=%b l=%b want f=1 l=0", f_gnt, l_gnt); end
        checks++; if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h8) begin errors++; $display("FAIL fo_mem: got en=%b we=%b addr=%h want 1 0 00000008", m_en, m_we, m_addr); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== mdl_mem[2]) begin errors++; $display("FAIL fo_resp: got v=%b d=%h want 1 %h", f_rvalid, f_rdata, mdl_mem[2]); end
        checks++; if (m_en !== 1'b0 || m_addr !== 32'h0) begin errors++; $display("FAIL fo_idle_bus: got en=%b addr=%h want 0 0", m_en, m_addr); end
        tick();
        settle();
        checks++; if (f_rvalid !== 1'b0 || f_rdata !== mdl_mem[2]) begin errors++; $display("FAIL fo_hold: got v=%b d=%h want 0 %h", f_rvalid, f_rdata, mdl_mem[2]); end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, 32'h20, 1, 0, 32'h24, 32'h0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0);
            settle();
            if (i < 4) begin
                checks++;
                if (f_gnt !== (i % 2 == 0) || l_gnt !== (i % 2 == 1)) begin
                    errors++; $display("FAIL rr_gnt cycle %0d: got f=%b l=%b want f=%b l=%b", i, f_gnt, l_gnt, i % 2 == 0, i % 2 == 1);
                end
            end
            if (i > 0) begin
                checks++;
                if (f_rvalid !== ((i - 1) % 2 == 0) || l_rvalid !== ((i - 1) % 2 == 1)) begin
                    errors++; $display("FAIL rr_rvalid cycle %0d: got f=%b l=%b want f=%b l=%b", i, f_rvalid, l_rvalid, (i - 1) % 2 == 0, (i - 1) % 2 == 1);
                end
                checks++;
                if (f_rdata !== mdl_mem[8]) begin errors++; $display("FAIL rr_f_rdata cycle %0d: got %h want %h", i, f_rdata, mdl_mem[8]); end
            end
            if (i > 1) begin
                checks++;
                if (l_rdata !== mdl_mem[9]) begin errors++; $display("FAIL rr_l_rdata cycle %0d: got %h want %h", i, l_rdata, mdl_mem[9]); end
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        do_reset();
        drive(0, 0, 1, 0, 32'h14, 32'h0, 0);
        settle(); tick();
        drive(0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
        settle();
        checks++; if (l_rvalid !== 1'b1 || l_rdata !== mdl_mem[5]) begin errors++; $display("FAIL wr_pre_read: got v=%b d=%h want 1 %h", l_rvalid, l_rdata, mdl_mem[5]); end
        checks++; if (l_gnt !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h10 || m_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_bus: got gnt=%b we=%b addr=%h wdata=%h want 1 1 00000010 deadbeef", l_gnt, m_we, m_addr, m_wdata);
        end
        tick();
        drive(1, 32'h10, 0, 0, 0, 0, 0);
        settle();
        checks++; if (l_rvalid !== 1'b1 || l_rdata !== 32'h0) begin errors++; $display("FAIL wr_ack: got v=%b d=%h want 1 00000000", l_rvalid, l_rdata); end
        checks++; if (f_gnt !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h10) begin errors++; $display("FAIL wr_fetch_bus: got gnt=%b we=%b addr=%h want 1 0 00000010", f_gnt, m_we, m_addr); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_readback: got v=%b d=%h want 1 deadbeef", f_rvalid, f_rdata); end
        checks++; if (l_rvalid !== 1'b0 || m_we !== 1'b0) begin errors++; $display("FAIL wr_single: got lv=%b we=%b want 0 0", l_rvalid, m_we); end
        tick();
    endtask

    task automatic test_reset_drop();
        do_reset();
        drive(1, 32'h4, 0, 0, 0, 0, 0);
        settle();
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL rd_accept: got %b want 1", f_gnt); end
        tick();
        rst = 1'b0;
        drive(1, 32'h8, 1, 0, 32'h28, 32'h0, 0);
        settle();
        checks++; if (f_rvalid !== 1'b0 || f_rdata !== 32'h0 || l_rvalid !== 1'b0) begin errors++; $display("FAIL rd_dropped: got fv=%b fd=%h lv=%b want 0 0 0", f_rvalid, f_rdata, l_rvalid); end
        checks++; if (f_gnt !== 1'b0 || l_gnt !== 1'b0 || m_en !== 1'b0 || m_addr !== 32'h0) begin
            errors++; $display("FAIL rd_outputs: got fg=%b lg=%b en=%b addr=%h want 0 0 0 0", f_gnt, l_gnt, m_en, m_addr);
        end
        tick();
        rst = 1'b1;
        settle();
        checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin errors++; $display("FAIL rd_first_tie: got f=%b l=%b want f=1 l=0", f_gnt, l_gnt); end
        checks++; if (f_rvalid !== 1'b0) begin errors++; $display("FAIL rd_no_resp: got %b want 0", f_rvalid); end
        tick();
    endtask

`ifdef IMEM_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        drive(1, 32'h30, 1, 0, 32'h34, 32'h0, 1);
        settle();
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL lk_first_tie: got %b want 1", f_gnt); end
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h38, 1, k[0], 32'h34 + 32'(4 * k), 32'(k + 7), 1);
            settle();
            checks++;
            if (f_gnt !== 1'b0 || l_gnt !== 1'b1) begin errors++; $display("FAIL lk_burst %0d: got f=%b l=%b want f=0 l=1", k, f_gnt, l_gnt); end
            if (k > 0) begin
                checks++;
                if (dbg_state !== LOCKED) begin errors++; $display("FAIL lk_state %0d: got %0d want LOCKED", k, dbg_state); end
            end
            tick();
        end
        drive(1, 32'h38, 1, 0, 32'h40, 32'h0, 0);
        settle();
        checks++; if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin errors++; $display("FAIL lk_release: got f=%b l=%b want f=1 l=0", f_gnt, l_gnt); end
        tick();
    endtask
`endif

    task automatic test_random();
        bit fp = 1'b0;
        bit lp = 1'b0;
        bit ev_f, ev_l, exp_en, exp_we;
        logic [31:0] exp_addr, exp_wd, exp_fd, exp_ld;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) != 0);
            if (!fp && $urandom_range(0, 3) != 0) begin
                fp = 1'b1; f_addr = $urandom;
            end
            if (!lp && $urandom_range(0, 2) != 0) begin
                lp = 1'b1; l_addr = $urandom; l_we = $urandom_range(0, 1) == 1; l_wdata = $urandom;
            end
            f_req = fp;
            l_req = lp;
`ifdef IMEM_ARB_LOCK_EN
            l_lock = ($urandom_range(0, 3) == 0);
`else
            l_lock = 1'b0;
`endif
            settle();
            exp_en   = (win != 0);
            exp_we   = (win == 2) && l_we;
            exp_addr = (win == 1) ? f_addr : ((win == 2) ? l_addr : 32'h0);
            exp_wd   = (win != 0) ? l_wdata : 32'h0;
            ev_f     = rst && ef_v;
            ev_l     = rst && el_v;
            exp_fd   = rst ? ef_d : 32'h0;
            exp_ld   = rst ? el_d : 32'h0;
            checks++; if (f_gnt !== (win == 1)) begin errors++; $display("FAIL rnd_f_gnt c%0d: got %b want %b", c, f_gnt, win == 1); end
            checks++; if (l_gnt !== (win == 2)) begin errors++; $display("FAIL rnd_l_gnt c%0d: got %b want %b", c, l_gnt, win == 2); end
            checks++; if (m_en !== exp_en) begin errors++; $display("FAIL rnd_m_en c%0d: got %b want %b", c, m_en, exp_en); end
            checks++; if (m_we !== exp_we) begin errors++; $display("FAIL rnd_m_we c%0d: got %b want %b", c, m_we, exp_we); end
            checks++; if (m_addr !== exp_addr) begin errors++; $display("FAIL rnd_m_addr c%0d: got %h want %h", c, m_addr, exp_addr); end
            checks++; if (m_wdata !== exp_wd) begin errors++; $display("FAIL rnd_m_wdata c%0d: got %h want %h", c, m_wdata, exp_wd); end
            checks++; if (f_rvalid !== ev_f) begin errors++; $display("FAIL rnd_f_rvalid c%0d: got %b want %b", c, f_rvalid, ev_f); end
            checks++; if (l_rvalid !== ev_l) begin errors++; $display("FAIL rnd_l_rvalid c%0d: got %b want %b", c, l_rvalid, ev_l); end
            checks++; if (f_rdata !== exp_fd) begin errors++; $display("FAIL rnd_f_rdata c%0d: got %h want %h", c, f_rdata, exp_fd); end
            checks++; if (l_rdata !== exp_ld) begin errors++; $display("FAIL rnd_l_rdata c%0d: got %h want %h", c, l_rdata, exp_ld); end
            if (win == 1) fp = 1'b0;
            if (win == 2) lp = 1'b0;
            tick();
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom | 32'h1;
            mdl_mem[i] = mem[i];
        end
        test_reset();
        test_fetch_only();
        test_round_robin();
        test_write_read();
        test_reset_drop();
`ifdef IMEM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of both requester ports.
REQ-002 SHALL have parameter DATA_W, default 32, instruction/data word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have fetch-side ports: f_req in 1 (fetch request), f_addr in ADDR_W, f_gnt out 1, f_rvalid out 1, f_rdata out DATA_W.
REQ-006 SHALL have loader-side ports: l_req in 1, l_we in 1 (1 = write), l_addr in ADDR_W, l_wdata in DATA_W, l_gnt out 1, l_rvalid out 1, l_rdata out DATA_W.
REQ-007 SHALL have port l_lock, input, 1, a loader burst-hold request; present only with IMEM_ARB_LOCK_EN.
REQ-008 SHALL have memory-side ports: m_en out 1, m_we out 1, m_addr out ADDR_W (byte address, memory indexes [ADDR_W-1:2]), m_wdata out DATA_W, m_rdata in DATA_W (combinational read).

Function
REQ-009 SHALL grant at most one requester per cycle: f_gnt and l_gnt are mutually exclusive and combinational from the requests and the arbiter state.
REQ-010 SHALL treat a request as accepted in the cycle where req=1 and gnt=1; the requester holds req/addr/data stable until then.
REQ-011 SHALL, in an accept cycle, drive m_en=1, m_addr and m_we from the winner; m_we=1 only for an accepted loader write; m_wdata=l_wdata.
REQ-012 SHALL hold m_en=0, m_we=0, m_addr=0 and m_wdata=0 in cycles with no accept.
REQ-013 SHALL register m_rdata at the accept edge and pulse the winner's rvalid for exactly one cycle on the next cycle (read latency 1).
REQ-014 SHALL pulse l_rvalid with l_rdata=0 one cycle after an accepted loader write (write acknowledge).
REQ-015 SHALL hold rdata outputs stable between rvalid pulses; a new accept may occur in the same cycle as the previous rvalid (throughput 1 access/cycle).
REQ-016 SHALL resolve a single request by granting it immediately.
REQ-017 SHALL resolve simultaneous requests round-robin via register last_gnt (0 = fetch, 1 = loader): the requester not in last_gnt wins.
REQ-018 SHALL update last_gnt only on accept cycles.
REQ-019 SHALL use FSM states IDLE and LOCKED; without IMEM_ARB_LOCK_EN the FSM remains in IDLE.
REQ-020 SHALL, in IDLE, move to LOCKED when a loader access is accepted with l_lock=1.
REQ-021 SHALL, in LOCKED, grant only the loader (f_gnt=0), and return to IDLE in the first cycle where l_lock=0; that cycle arbitrates normally.
REQ-022 SHALL never address-check; addresses beyond the array wrap per the memory's word indexing.

Reset
REQ-023 SHALL, while rst=0 at a clock edge, set state=IDLE, last_gnt=1 (so fetch wins the first tie), f_rvalid=0, l_rvalid=0, f_rdata=0, l_rdata=0.
REQ-024 SHALL force f_gnt=0, l_gnt=0, m_en=0 and m_we=0 combinationally while rst=0.
REQ-025 SHALL drop any response pending from the cycle before reset assertion; no rvalid is issued for it.

Configuration
REQ-026 SHALL provide macro IMEM_ARB_LOCK_EN: when defined, l_lock and the LOCKED state exist; when undefined, the port is absent and arbitration is pure round-robin.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, LOCKED) and the requester-id constants (REQ_FETCH=0, REQ_LOADER=1) in shared package imem_pkg.
REQ-028 SHALL implement the round-robin grant as one sub-module rr_arb2 (two requests, last_gnt in, one-hot grant out); everything else stays in imem_arbiter.

Verification
REQ-029 SHALL cover: fetch only, f_addr=0x8 -> f_gnt=1, m_addr=0x8 same cycle; f_rvalid=1 with f_rdata=mem[2] next cycle.
REQ-030 SHALL cover: both requesting for 4 cycles after reset -> grants F,L,F,L; each rvalid arrives one cycle after its grant.
REQ-031 SHALL cover: loader write 0xDEADBEEF to 0x10, then fetch 0x10 -> m_we=1 for one cycle only, l_rvalid with l_rdata=0, then f_rdata=0xDEADBEEF.
REQ-032 SHALL cover: with IMEM_ARB_LOCK_EN, l_lock=1 for 3 loader accesses while f_req=1 -> f_gnt=0 throughout; fetch is granted the cycle l_lock falls.
REQ-033 SHALL cover: rst=0 asserted in the cycle after a fetch accept -> f_rvalid stays 0, all outputs 0, and the first tie after release goes to fetch.
